// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: bubble encoding, default
// reset PC and the fetch FSM state type.
// Ports: none (package).
package mips_pkg;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_dec_reg.sv
// IF/DEC pipeline register with flush > stall > load > bubble priority.
// Latency: one cycle from load to outputs.
// Backpressure: stall holds all fields; flush inserts a bubble and keeps pc_plus4.
// Ports: flush/stall/load controls, load_instr/load_pc_plus4 data in,
//        instr/pc_plus4/valid registered out.
module if_dec_reg #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0000_0000;
            valid    <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr    <= load_instr;
                pc_plus4 <= load_pc_plus4;
                valid    <= 1'b1;
            end else begin
                // nothing arrived this cycle: present a bubble downstream
                instr <= NOP_INSTR;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake FSM, hold buffer, redirect latch.
// Latency: word appears on instr_DEC one cycle after its imem ack.
// Backpressure: stall_if parks an acked word in a hold buffer and drops imem_req.
// Ports: redirect (pcsrc_MEM/pc_branch_MEM), hazard controls (stall_if, flush_if,
//        flush_if_dec), imem req/addr/ack/rdata, IF/DEC outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcsrc_MEM,
    input  logic [31:0] pc_branch_MEM,
    input  logic        stall_if,
    input  logic        flush_if,
    input  logic        flush_if_dec,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_DEC,
    output logic [31:0] pc_plus4_DEC,
    output logic        valid_DEC
);

    import mips_pkg::*;

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  redir, redir_nxt;
    logic [31:0]  hold_instr, hold_pc4;
    logic         hold_wr;
    logic         ifd_load;
    logic [31:0]  ifd_instr, ifd_pc4;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;

    assign pc_plus4  = pc + 32'd4;                       // wraps modulo 2^32
    assign target    = {pc_branch_MEM[31:2], 2'b00};
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            redir      <= 32'h0000_0000;
            hold_instr <= NOP_INSTR;
            hold_pc4   <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            redir <= redir_nxt;
            if (hold_wr) begin
                hold_instr <= imem_rdata;
                hold_pc4   <= pc_plus4;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        redir_nxt = redir;
        hold_wr   = 1'b0;
        ifd_load  = 1'b0;
        ifd_instr = imem_rdata;
        ifd_pc4   = pc_plus4;
        imem_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (pcsrc_MEM) begin
                        pc_nxt = target;
                    end else if (flush_if) begin
                        pc_nxt = pc;                     // refetch same address
                    end else if (stall_if) begin
                        hold_wr   = 1'b1;
                        pc_nxt    = pc_plus4;
                        state_nxt = ST_HOLD;
                    end else begin
                        ifd_load = 1'b1;
                        pc_nxt   = pc_plus4;
                    end
                end else if (pcsrc_MEM) begin
                    // transaction in flight: keep address stable, finish it, then redirect
                    redir_nxt = target;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                imem_req = 1'b1;
                if (pcsrc_MEM) begin
                    redir_nxt = target;
                end
                if (imem_ack) begin
                    pc_nxt    = pcsrc_MEM ? target : redir;
                    state_nxt = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (pcsrc_MEM) begin
                    pc_nxt    = target;
                    state_nxt = ST_FETCH;
                end else if (!stall_if) begin
                    ifd_load  = 1'b1;
                    ifd_instr = hold_instr;
                    ifd_pc4   = hold_pc4;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    if_dec_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_dec_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush_if_dec),
        .stall         (stall_if),
        .load          (ifd_load),
        .load_instr    (ifd_instr),
        .load_pc_plus4 (ifd_pc4),
        .instr         (instr_DEC),
        .pc_plus4      (pc_plus4_DEC),
        .valid         (valid_DEC)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, streaming, stall/hold, redirect
// with delayed ack, flushes, PC wrap and reset during a drain.
// Ports: none (top-level bench).
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pcsrc_MEM;
    logic [31:0] pc_branch_MEM;
    logic        stall_if;
    logic        flush_if;
    logic        flush_if_dec;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_DEC;
    logic [31:0] pc_plus4_DEC;
    logic        valid_DEC;

    int checks = 0;
    int errors = 0;

    // memory image: each word tags its own low address bits
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcsrc_MEM     (pcsrc_MEM),
        .pc_branch_MEM (pc_branch_MEM),
        .stall_if      (stall_if),
        .flush_if      (flush_if),
        .flush_if_dec  (flush_if_dec),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_DEC     (instr_DEC),
        .pc_plus4_DEC  (pc_plus4_DEC),
        .valid_DEC     (valid_DEC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        pcsrc_MEM     = 1'b0;
        pc_branch_MEM = 32'h0;
        stall_if      = 1'b0;
        flush_if      = 1'b0;
        flush_if_dec  = 1'b0;
        imem_ack      = 1'b1;

        // reset state
        tick(); tick();
        chk("rst_req",   32'(imem_req),  32'h0);
        chk("rst_instr", instr_DEC,      32'h0000_0000);
        chk("rst_pc4",   pc_plus4_DEC,   32'h0);
        chk("rst_valid", 32'(valid_DEC), 32'h0);

        // streaming with ack tied high
        rst_n = 1'b1;
        tick();
        chk("s0_req",   32'(imem_req), 32'h1);
        chk("s0_addr",  imem_addr,     32'h0);
        tick();
        chk("s1_addr",  imem_addr,     32'h4);
        chk("s1_instr", instr_DEC,     32'hC0DE_0000);
        chk("s1_valid", 32'(valid_DEC), 32'h1);
        chk("s1_pc4",   pc_plus4_DEC,  32'h4);
        tick();
        chk("s2_addr",  imem_addr,     32'h8);
        chk("s2_instr", instr_DEC,     32'hC0DE_0004);
        chk("s2_pc4",   pc_plus4_DEC,  32'h8);

        // stall for three cycles; word at 8 is acked on the first
        stall_if = 1'b1;
        tick();
        chk("st1_req",   32'(imem_req), 32'h0);
        chk("st1_instr", instr_DEC,     32'hC0DE_0004);
        tick();
        chk("st2_req",   32'(imem_req), 32'h0);
        tick();
        chk("st3_req",   32'(imem_req), 32'h0);
        chk("st3_instr", instr_DEC,     32'hC0DE_0004);
        stall_if = 1'b0;
        tick();
        chk("rel_instr", instr_DEC,     32'hC0DE_0008);
        chk("rel_pc4",   pc_plus4_DEC,  32'hC);
        chk("rel_valid", 32'(valid_DEC), 32'h1);
        chk("rel_addr",  imem_addr,     32'hC);
        tick();
        chk("post_instr", instr_DEC,    32'hC0DE_000C);
        chk("post_addr",  imem_addr,    32'h10);

        // redirect while the fetch at 0x10 is waiting for ack
        imem_ack      = 1'b0;
        pcsrc_MEM     = 1'b1;
        pc_branch_MEM = 32'h0000_0103;
        tick();
        pcsrc_MEM = 1'b0;
        chk("dr1_req",   32'(imem_req),  32'h1);
        chk("dr1_addr",  imem_addr,      32'h10);
        chk("dr1_valid", 32'(valid_DEC), 32'h0);
        tick();
        chk("dr2_addr",  imem_addr,      32'h10);
        imem_ack = 1'b1;
        tick();
        chk("redir_addr",  imem_addr,      32'h100);
        chk("redir_valid", 32'(valid_DEC), 32'h0);
        chk("redir_instr", instr_DEC,      32'h0000_0000);
        tick();
        chk("tgt_instr", instr_DEC, 32'hC0DE_0100);
        chk("tgt_addr",  imem_addr, 32'h104);

        // flush_if_dec together with stall_if wins and keeps pc_plus4
        imem_ack     = 1'b0;
        flush_if_dec = 1'b1;
        stall_if     = 1'b1;
        tick();
        chk("fd_instr", instr_DEC,      32'h0000_0000);
        chk("fd_valid", 32'(valid_DEC), 32'h0);
        chk("fd_pc4",   pc_plus4_DEC,   32'h104);
        flush_if_dec = 1'b0;
        stall_if     = 1'b0;

        // flush_if on ack: word dropped, same address refetched
        imem_ack = 1'b1;
        flush_if = 1'b1;
        tick();
        chk("fi_addr",  imem_addr,      32'h104);
        chk("fi_valid", 32'(valid_DEC), 32'h0);
        flush_if = 1'b0;

        // redirect to the top word, then wrap
        pcsrc_MEM     = 1'b1;
        pc_branch_MEM = 32'hFFFF_FFFE;
        tick();
        pcsrc_MEM = 1'b0;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr",  imem_addr,    32'h0);
        chk("wrap_pc4",   pc_plus4_DEC, 32'h0);
        chk("wrap_instr", instr_DEC,    32'hC0DE_FFFC);

        // redirect while holding drops the buffered word
        stall_if = 1'b1;
        tick();
        chk("hb_req", 32'(imem_req), 32'h0);
        pcsrc_MEM     = 1'b1;
        pc_branch_MEM = 32'h0000_0040;
        tick();
        chk("hr_addr",  imem_addr,     32'h40);
        chk("hr_req",   32'(imem_req), 32'h1);
        chk("hr_instr", instr_DEC,     32'hC0DE_FFFC);
        pcsrc_MEM = 1'b0;
        stall_if  = 1'b0;
        tick();
        chk("hr_next", instr_DEC, 32'hC0DE_0040);
        chk("hr_nadr", imem_addr, 32'h44);

        // reset asserted during a drain, then a late ack
        imem_ack      = 1'b0;
        pcsrc_MEM     = 1'b1;
        pc_branch_MEM = 32'h0000_0080;
        tick();
        pcsrc_MEM = 1'b0;
        chk("rd_req",  32'(imem_req), 32'h1);
        chk("rd_addr", imem_addr,     32'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("rd_rst_req",   32'(imem_req),  32'h0);
        chk("rd_rst_instr", instr_DEC,      32'h0000_0000);
        chk("rd_rst_pc4",   pc_plus4_DEC,   32'h0);
        chk("rd_rst_valid", 32'(valid_DEC), 32'h0);
        imem_ack = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rr_addr",  imem_addr,      32'h0);
        chk("rr_valid", 32'(valid_DEC), 32'h0);
        tick();
        chk("rr_instr", instr_DEC,      32'hC0DE_0000);
        chk("rr_pc4",   pc_plus4_DEC,   32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0000, bubble encoding (sll $0,$0,0).
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 pcsrc_MEM  in  1  taken branch/jump resolved in MEM; redirect request.
REQ-007 pc_branch_MEM  in  32  redirect target; bits [1:0] ignored, forced 2'b00.
REQ-008 stall_if  in  1  hazard stall; hold PC and IF/DEC register.
REQ-009 flush_if  in  1  kill the instruction word completing this cycle.
REQ-010 flush_if_dec  in  1  load bubble into IF/DEC register.
REQ-011 imem_req  out  1  instruction memory request.
REQ-012 imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
REQ-013 imem_ack  in  1  transfer completes on an edge where imem_req=1 and imem_ack=1; zero-wait ack legal.
REQ-014 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-015 instr_DEC  out  32  IF/DEC instruction.
REQ-016 pc_plus4_DEC  out  32  PC+4 of instr_DEC.
REQ-017 valid_DEC  out  1  instr_DEC holds a real instruction.

Function
REQ-018 States: IDLE, FETCH, HOLD, DRAIN; registered; one-hot or binary is free.
REQ-019 IDLE: imem_req=0; next state FETCH unconditionally; PC=RESET_PC.
REQ-020 FETCH: imem_req=1, imem_addr=pc.
REQ-021 FETCH, ack, pcsrc_MEM=1: discard word; pc<=target; stay FETCH.
REQ-022 FETCH, ack, flush_if=1, pcsrc_MEM=0: discard word; PC unchanged; stay FETCH (refetch).
REQ-023 FETCH, ack, stall_if=1, no pcsrc_MEM/flush_if: word and pc into hold buffer; pc<=pc+4; go HOLD.
REQ-024 FETCH, ack, no stall/flush/redirect: IF/DEC<= {rdata, pc+4, valid=1}; pc<=pc+4; stay FETCH.
REQ-025 FETCH, no ack, pcsrc_MEM=1: latch target in redirect register; go DRAIN; imem_addr unchanged.
REQ-026 DRAIN: imem_req=1 at old address; on ack discard word, pc<=latched target, go FETCH; a further pcsrc_MEM in DRAIN overwrites the latched target.
REQ-027 HOLD: imem_req=0; pcsrc_MEM=1 -> drop buffer, pc<=target, FETCH; else stall_if=0 -> buffer into IF/DEC (valid=1), FETCH; else stay.
REQ-028 IF/DEC priority per edge: flush_if_dec (instr=NOP_INSTR, valid=0, pc_plus4 unchanged) > stall_if (hold) > new load > no load (valid<=0, instr<=NOP_INSTR).
REQ-029 pcsrc_MEM beats stall_if and flush_if in all states.
REQ-030 PC arithmetic modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000; pc[1:0] always 2'b00.
REQ-031 At most one outstanding imem transaction; imem_req never drops before ack in FETCH/DRAIN.

Reset
REQ-032 rst_n=0 forces immediately: state IDLE, pc=RESET_PC, imem_req=0, instr_DEC=NOP_INSTR, pc_plus4_DEC=0, valid_DEC=0, buffers cleared.
REQ-033 Reset mid-transaction abandons it; a late ack after reset is ignored (IDLE has imem_req=0).

Structure
REQ-034 Shared package mips_pkg holds NOP_INSTR, RESET_PC default, and enum fetch_state_t.
REQ-035 IF/DEC register is sub-module if_dec_reg (flush/stall/load priority of REQ-028); FSM, PC and buffers stay in fetch_stage.

Verification
REQ-036 Reset release, ack tied 1: imem_addr 0,4,8 on consecutive cycles; instr_DEC follows one cycle later, valid_DEC=1.
REQ-037 stall_if=1 for 3 cycles with ack on first: one word buffered, imem_req=0 for stall cycles, on release instr_DEC=buffered word, no word lost or duplicated.
REQ-038 pcsrc_MEM=1, target 32'h0000_0103, ack delayed 2 cycles: addr held at old PC until ack, old word discarded, next imem_addr=32'h0000_0100.
REQ-039 flush_if_dec and stall_if together: instr_DEC=NOP_INSTR, valid_DEC=0.
REQ-040 pc=32'hFFFF_FFFC fetched: next imem_addr=32'h0000_0000.
REQ-041 rst_n low during DRAIN then ack pulse: outputs at reset values, first post-reset fetch at RESET_PC.
